tohost_mailbox: RTL and testbench
=================================

TOHOST_MAILBOX -- requirements
Module: tohost_mailbox

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 32'h8000_1000, byte address of the 64-bit tohost word.
REQ-002 SHALL have parameter FROMHOST_ADDR, default 32'h8000_1040, byte address of the 64-bit fromhost word.
REQ-003 SHALL have parameter DEPTH, default 4, pending-message FIFO depth; power of 2, minimum 2.
REQ-004 SHALL have port clock, input, 1, sole clock; all state on posedge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port wr_valid, input, 1, DUT store request valid.
REQ-007 SHALL have port wr_ready, output, 1, store accepted when wr_valid && wr_ready.
REQ-008 SHALL have port wr_addr, input, 32, store byte address, 8-byte aligned.
REQ-009 SHALL have port wr_data, input, 64, store data.
REQ-010 SHALL have port wr_mask, input, 8, byte strobes; bit i covers wr_data[8i+7:8i].
REQ-011 SHALL have port tohost, output, 64, head message presented to the bench.
REQ-012 SHALL have port tohost_valid, output, 1, head message valid.
REQ-013 SHALL have port tohost_clear, input, 1, bench pop strobe; ignored unless tohost_valid.
REQ-014 SHALL have port fromhost, output, 64, fromhost word readable by the DUT.
REQ-015 SHALL have port overflow, output, 1, sticky; a message was dropped.

Function
REQ-016 SHALL treat a store as a tohost write iff accepted and wr_addr == TOHOST_ADDR; all other addresses except FROMHOST_ADDR SHALL be accepted and ignored.
REQ-017 SHALL merge strobed bytes of tohost writes into a 64-bit staging register.
REQ-018 SHALL enqueue staging|new-bytes to the FIFO in the same cycle that a tohost write has wr_mask[7]=1, then clear staging to 0; the high word is written last.
REQ-019 SHALL hold staging without enqueue for tohost writes with wr_mask[7]=0.
REQ-020 SHALL drive wr_ready = 1 always; on enqueue with FIFO full it SHALL drop the message and set overflow.
REQ-021 SHALL drive tohost = FIFO head and tohost_valid = !empty, registered; first visibility one cycle after the enqueuing cycle.
REQ-022 SHALL pop the head on tohost_clear && tohost_valid; the next head is visible the following cycle.
REQ-023 SHALL permit a simultaneous enqueue and pop when full; this is not an overflow.
REQ-024 SHALL use FSM IDLE (empty) -> PRESENT (tohost_valid) -> ACK (one cycle after each pop) -> PRESENT if non-empty, else IDLE.
REQ-025 SHALL write fromhost = {32'h0, pop count} on entering ACK; pop count is 32-bit and wraps at 2^32.
REQ-026 SHALL let a DUT store to FROMHOST_ADDR overwrite strobed bytes of fromhost; a bench update in the same cycle SHALL take priority.
REQ-027 SHALL wrap FIFO pointers modulo DEPTH, with one extra bit for full/empty detection.

Reset
REQ-028 SHALL clear on reset: staging, FIFO pointers, tohost=0, tohost_valid=0, fromhost=0, overflow=0, pop count=0, state=IDLE; wr_ready=1.
REQ-029 SHALL discard a partially merged message and all queued messages on reset asserted mid-operation.

Structure
REQ-030 SHALL place the state enum (IDLE, PRESENT, ACK) and default TOHOST/FROMHOST addresses in the shared package tohost_pkg.
REQ-031 SHALL implement the queue as sub-module tohost_fifo (DEPTH x 64, push/pop/full/empty); merge logic and FSM stay in tohost_mailbox.

Verification
REQ-032 Single write: mask 8'hFF, data 64'h1 to TOHOST_ADDR -> next cycle tohost=1, tohost_valid=1; after clear, fromhost=1 in ACK, then IDLE.
REQ-033 Split write: mask 8'h0F, data 0x...0000_0005, then mask 8'hF0, data 0x0000_0003_0000_0000 -> exactly one message 64'h0000_0003_0000_0005.
REQ-034 Overflow: 5 full writes (data 1..5) with DEPTH=4 and no clear -> overflow=1; pops return 1,2,3,4 only.
REQ-035 Simultaneous enqueue and pop when full: data 9 written with tohost_clear=1 -> overflow stays 0; 9 appears last.
REQ-036 Reset mid-merge: low-half write, reset pulse, high-half write of 0x0000_0007_xxxx -> message 64'h0000_0007_0000_0000.
REQ-037 Non-target write: full write to 32'h8000_2000 -> tohost_valid stays 0, overflow 0.

Source files
------------

// File: rtl/tohost_pkg.sv
// Shared types and defaults for the tohost/fromhost mailbox.
package tohost_pkg;

   // Default byte addresses of the 64-bit tohost and fromhost words.
   localparam logic [31:0] TOHOST_ADDR_DEF   = 32'h8000_1000;
   localparam logic [31:0] FROMHOST_ADDR_DEF = 32'h8000_1040;

   // Mailbox handshake state as seen by the bench.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,  // queue empty, nothing presented
      PRESENT = 2'd1,  // head message presented on tohost
      ACK     = 2'd2   // one cycle after a pop; fromhost holds the pop count
   } mbox_state_e;

   // Replace the bytes of old_word selected by mask with those of new_word.
   function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  mask);
      logic [63:0] res;
      res = old_word;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/tohost_fifo.sv
// Pending-message queue, DEPTH x 64. Besides full it exposes the head and
// emptiness the queue will have after this cycle's push/pop, so the owner
// can register its outputs and still show a new head one cycle after push.
module tohost_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  logic [63:0] push_data,
   input  logic        pop,
   output logic        full,
   output logic        empty_next,
   output logic [63:0] head_next
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = AW + 1;  // extra wrap bit tells full from empty

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW-1:0] wr_ptr_n, rd_ptr_n;
   logic          empty;
   logic          do_push, do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A push into a full queue is only taken when the head leaves at the same time.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign wr_ptr_n = do_push ? wr_ptr + PW'(1) : wr_ptr;
   assign rd_ptr_n = do_pop  ? rd_ptr + PW'(1) : rd_ptr;

   assign empty_next = (wr_ptr_n == rd_ptr_n);

   // Forward push data when the next head is the slot being written right now.
   always_comb begin
      head_next = mem[rd_ptr_n[AW-1:0]];
      if (do_push && (rd_ptr_n == wr_ptr)) head_next = push_data;
   end

   // Pointer update; reset empties the queue.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
      end
   end

   // Storage write; contents are don't-care until a pointer covers them.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/tohost_mailbox.sv
// tohost/fromhost mailbox between a core under test and the bench. Stores to
// the tohost word merge into a staging register; the store carrying the top
// byte completes the message and queues it. The bench sees the queue head on
// tohost, pops it with tohost_clear, and the running pop count is written
// back to fromhost as an acknowledgement.
module tohost_mailbox
   import tohost_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR   = TOHOST_ADDR_DEF,
   parameter logic [31:0] FROMHOST_ADDR = FROMHOST_ADDR_DEF,
   parameter int          DEPTH         = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_addr,
   input  logic [63:0] wr_data,
   input  logic [7:0]  wr_mask,
   output logic [63:0] tohost,
   output logic        tohost_valid,
   input  logic        tohost_clear,
   output logic [63:0] fromhost,
   output logic        overflow
);

   mbox_state_e state, state_n;
   logic [63:0] staging, merged;
   logic [31:0] pop_cnt;
   logic        th_wr, fh_wr, enq, pop, ack_load;
   logic        fifo_full, fifo_empty_n;
   logic [63:0] fifo_head_n;

   // Stores are never back-pressured; a full queue drops instead.
   assign wr_ready = 1'b1;

   assign th_wr  = wr_valid && (wr_addr == TOHOST_ADDR);
   assign fh_wr  = wr_valid && (wr_addr == FROMHOST_ADDR);
   assign merged = merge_bytes(staging, wr_data, wr_mask);
   assign enq    = th_wr && wr_mask[7];  // high word lands last
   assign pop    = tohost_clear && tohost_valid;

   tohost_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (enq),
      .push_data  (merged),
      .pop        (pop),
      .full       (fifo_full),
      .empty_next (fifo_empty_n),
      .head_next  (fifo_head_n)
   );

   // Staging collects partial writes; a completed message restarts it at zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)      staging <= '0;
      else if (enq)   staging <= '0;
      else if (th_wr) staging <= merged;
   end

   // Registered view of the queue head for the bench.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tohost       <= '0;
         tohost_valid <= 1'b0;
      end else begin
         tohost       <= fifo_empty_n ? 64'h0 : fifo_head_n;
         tohost_valid <= !fifo_empty_n;
      end
   end

   // Sticky drop flag; a push that coincides with a pop always fits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                            overflow <= 1'b0;
      else if (enq && fifo_full && !pop)    overflow <= 1'b1;
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state; every pop enters ACK and loads the acknowledgement.
   always_comb begin
      state_n  = state;
      ack_load = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty_n) state_n = PRESENT;
         end
         PRESENT, ACK: begin
            if (pop) begin
               state_n  = ACK;
               ack_load = 1'b1;
            end else if (state == ACK) begin
               state_n = fifo_empty_n ? IDLE : PRESENT;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Pop counter, wraps naturally at 2^32.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         pop_cnt <= '0;
      else if (ack_load) pop_cnt <= pop_cnt + 32'd1;
   end

   // fromhost: the acknowledgement wins over a same-cycle core store.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         fromhost <= '0;
      else if (ack_load) fromhost <= {32'h0, pop_cnt + 32'd1};
      else if (fh_wr)    fromhost <= merge_bytes(fromhost, wr_data, wr_mask);
   end

endmodule

// File: tb/tb_tohost_mailbox.sv
// Directed bench for tohost_mailbox with hand-computed expectations.
module tb_tohost_mailbox;
   import tohost_pkg::*;

   localparam logic [31:0] TH = 32'h8000_1000;
   localparam logic [31:0] FH = 32'h8000_1040;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;
   logic [7:0]  wr_mask;
   logic [63:0] tohost;
   logic        tohost_valid;
   logic        tohost_clear;
   logic [63:0] fromhost;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   tohost_mailbox #(.TOHOST_ADDR(TH), .FROMHOST_ADDR(FH), .DEPTH(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_mask      (wr_mask),
      .tohost       (tohost),
      .tohost_valid (tohost_valid),
      .tohost_clear (tohost_clear),
      .fromhost     (fromhost),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // One cycle of stimulus, then inputs return to idle.
   task automatic drv(input logic v, input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] m, input logic clr);
      wr_valid = v; wr_addr = a; wr_data = d; wr_mask = m; tohost_clear = clr;
      cyc();
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; tohost_clear = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; tohost_clear = 1'b0;
      reset = 1'b1;
      cyc();
      total++; if (tohost_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", tohost_valid); end
      total++; if (tohost !== 64'h0) begin bad++; $display("FAIL reset_tohost got=%h exp=0", tohost); end
      total++; if (fromhost !== 64'h0) begin bad++; $display("FAIL reset_fromhost got=%h exp=0", fromhost); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
      reset = 1'b0;
      cyc();
      total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
   endtask

   task automatic test_single();
      drv(1'b1, TH, 64'h1, 8'hFF, 1'b0);
      total++; if (tohost_valid !== 1'b1 || tohost !== 64'h1) begin bad++; $display("FAIL single_present got=%b/%h exp=1/1", tohost_valid, tohost); end
      total++; if (dut.state !== PRESENT) begin bad++; $display("FAIL single_state_present got=%0d", dut.state); end
      drv(1'b0, '0, '0, 8'h0, 1'b1);
      total++; if (fromhost !== 64'h1) begin bad++; $display("FAIL single_fromhost got=%h exp=1", fromhost); end
      total++; if (dut.state !== ACK || tohost_valid !== 1'b0) begin bad++; $display("FAIL single_ack got=%0d/%b", dut.state, tohost_valid); end
      cyc();
      total++; if (dut.state !== IDLE) begin bad++; $display("FAIL single_idle got=%0d exp=%0d", dut.state, IDLE); end
   endtask

   task automatic test_split();
      drv(1'b1, TH, 64'h1111_2222_0000_0005, 8'h0F, 1'b0);
      total++; if (tohost_valid !== 1'b0) begin bad++; $display("FAIL split_early got=%b exp=0", tohost_valid); end
      drv(1'b1, TH, 64'h0000_0003_0000_0000, 8'hF0, 1'b0);
      total++; if (tohost_valid !== 1'b1 || tohost !== 64'h0000_0003_0000_0005) begin bad++; $display("FAIL split_msg got=%b/%h exp=1/0000000300000005", tohost_valid, tohost); end
      drv(1'b0, '0, '0, 8'h0, 1'b1);
      total++; if (tohost_valid !== 1'b0 || fromhost !== 64'h2) begin bad++; $display("FAIL split_one_msg got=%b/%h exp=0/2", tohost_valid, fromhost); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         drv(1'b1, TH, 64'(i), 8'hFF, 1'b0);
         if (i == 4) begin
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
         end
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      total++; if (tohost !== 64'h1) begin bad++; $display("FAIL ovf_head got=%h exp=1", tohost); end
      // Back-to-back pops with clear held high.
      tohost_clear = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         cyc();
         total++; if (tohost_valid !== 1'b1 || tohost !== 64'(i)) begin bad++; $display("FAIL ovf_pop%0d got=%b/%h exp=1/%0d", i, tohost_valid, tohost, i); end
      end
      cyc();
      tohost_clear = 1'b0;
      total++; if (tohost_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", tohost_valid); end
      total++; if (fromhost !== 64'h6) begin bad++; $display("FAIL ovf_popcnt got=%h exp=6", fromhost); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_q [4];
      exp_q[0] = 64'h3; exp_q[1] = 64'h4; exp_q[2] = 64'h9; exp_q[3] = 64'h0;
      do_reset();
      for (int i = 1; i <= 4; i++) drv(1'b1, TH, 64'(i), 8'hFF, 1'b0);
      drv(1'b1, TH, 64'h9, 8'hFF, 1'b1);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_no_ovf got=%b exp=0", overflow); end
      total++; if (tohost !== 64'h2) begin bad++; $display("FAIL b2b_head got=%h exp=2", tohost); end
      for (int i = 0; i < 3; i++) begin
         drv(1'b0, '0, '0, 8'h0, 1'b1);
         total++; if (tohost_valid !== 1'b1 || tohost !== exp_q[i]) begin bad++; $display("FAIL b2b_pop%0d got=%b/%h exp=1/%h", i, tohost_valid, tohost, exp_q[i]); end
      end
      drv(1'b0, '0, '0, 8'h0, 1'b1);
      total++; if (tohost_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b/%b exp=0/0", tohost_valid, overflow); end
   endtask

   task automatic test_reset_mid_merge();
      drv(1'b1, TH, 64'h1111_1111_2222_2222, 8'h0F, 1'b0);
      do_reset();
      drv(1'b1, TH, 64'h0000_0007_AAAA_AAAA, 8'hF0, 1'b0);
      total++; if (tohost_valid !== 1'b1 || tohost !== 64'h0000_0007_0000_0000) begin bad++; $display("FAIL midrst_msg got=%b/%h exp=1/0000000700000000", tohost_valid, tohost); end
      drv(1'b0, '0, '0, 8'h0, 1'b1);
      total++; if (fromhost !== 64'h1) begin bad++; $display("FAIL midrst_popcnt got=%h exp=1", fromhost); end
   endtask

   task automatic test_nontarget();
      drv(1'b1, 32'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
      cyc();
      total++; if (tohost_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL nontarget got=%b/%b exp=0/0", tohost_valid, overflow); end
   endtask

   task automatic test_fromhost();
      drv(1'b1, FH, 64'hFFFF_FFFF_FFFF_1234, 8'h03, 1'b0);
      total++; if (fromhost !== 64'h0000_0000_0000_1234) begin bad++; $display("FAIL fh_low got=%h exp=0000000000001234", fromhost); end
      drv(1'b1, FH, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0);
      total++; if (fromhost !== 64'hDEAD_BEEF_0000_1234) begin bad++; $display("FAIL fh_high got=%h exp=deadbeef00001234", fromhost); end
      drv(1'b1, TH, 64'h42, 8'hFF, 1'b0);
      drv(1'b1, FH, 64'h5555_5555_5555_5555, 8'hFF, 1'b1);
      total++; if (fromhost !== 64'h2) begin bad++; $display("FAIL fh_priority got=%h exp=2", fromhost); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_split();
      test_overflow();
      test_back_to_back();
      test_reset_mid_merge();
      test_nontarget();
      test_fromhost();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
